// File: rtl/manch_encoder_if.sv
// Parallel-in / serial-out bus for the Manchester transmitter.
// The master side supplies words through a valid/ready handshake. The slave
// side (the encoder) drives the line and the frame status.
interface manch_encoder_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              dataout;
    logic              busy;
    logic              tx_done;

    modport master (
        output din, din_valid,
        input  din_ready, dataout, busy, tx_done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, dataout, busy, tx_done
    );
endinterface

// File: rtl/manch_encoder.sv
// Manchester line transmitter (IEEE 802.3 polarity: 1 = low-then-high).
// A frame is made of an alternating preamble, the payload sent MSB-first, and
// an idle gap. The counters always describe the symbol currently on the line.
// The line register is loaded from the symbol of the *next* cycle, so
// dataout changes only on clock edges and every half-bit lasts exactly
// HALF_BIT_CLKS cycles.
module manch_encoder #(
    parameter int DATA_W        = 8,
    parameter int HALF_BIT_CLKS = 4,
    parameter int PREAMBLE_BITS = 8,
    parameter int GAP_BITS      = 2
) (
    input  logic            clk,
    input  logic            rst,
    manch_encoder_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam int MAX_BITS_A = (PREAMBLE_BITS > DATA_W) ? PREAMBLE_BITS : DATA_W;
    localparam int MAX_BITS   = (MAX_BITS_A > GAP_BITS) ? MAX_BITS_A : GAP_BITS;
    localparam int BC_W       = $clog2(MAX_BITS + 1);
    localparam int HC_W       = $clog2(HALF_BIT_CLKS + 1);

    localparam logic [HC_W-1:0] HALF_LAST = HC_W'(HALF_BIT_CLKS - 1);
    localparam logic [BC_W-1:0] PRE_LAST  = BC_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
    localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_W - 1);
    localparam logic [BC_W-1:0] GAP_LAST  = BC_W'(GAP_BITS - 1);

    logic [1:0]        r_state;
    logic [HC_W-1:0]   r_half_cnt;
    logic              r_phase;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_dataout;

    logic              w_half_end;
    logic              w_bit_end;
    logic              w_last_bit;
    logic [1:0]        w_state_next;
    logic [HC_W-1:0]   w_half_cnt_next;
    logic              w_phase_next;
    logic [BC_W-1:0]   w_bit_cnt_next;
    logic [DATA_W-1:0] w_shift_next;
    logic              w_sym_bit;
    logic              w_dataout_next;
    logic              w_tx_done;

    // Next-state, counter advance and the symbol to present in the next cycle
    always_comb begin
        w_state_next    = r_state;
        w_half_cnt_next = r_half_cnt;
        w_phase_next    = r_phase;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_sym_bit       = 1'b0;
        w_dataout_next  = 1'b0;

        w_half_end = (r_half_cnt == HALF_LAST);
        w_bit_end  = w_half_end && r_phase;

        case (r_state)
            S_PRE:   w_last_bit = (r_bit_cnt == PRE_LAST);
            S_DATA:  w_last_bit = (r_bit_cnt == DATA_LAST);
            S_GAP:   w_last_bit = (r_bit_cnt == GAP_LAST);
            default: w_last_bit = 1'b0;
        endcase

        if (r_state == S_IDLE) begin
            if (bus.din_valid) begin
                w_state_next    = (PREAMBLE_BITS > 0) ? S_PRE : S_DATA;
                w_half_cnt_next = '0;
                w_phase_next    = 1'b0;
                w_bit_cnt_next  = '0;
                w_shift_next    = bus.din;
            end
        end else begin
            w_half_cnt_next = w_half_end ? '0 : r_half_cnt + HC_W'(1);
            if (w_half_end) begin
                w_phase_next = ~r_phase;
            end
            if (w_bit_end) begin
                // Payload advances only at bit boundaries; the MSB is always the live bit
                if (r_state == S_DATA) begin
                    w_shift_next = r_shift << 1;
                end
                if (w_last_bit) begin
                    w_bit_cnt_next = '0;
                    case (r_state)
                        S_PRE:   w_state_next = S_DATA;
                        S_DATA:  w_state_next = S_GAP;
                        default: w_state_next = S_IDLE;
                    endcase
                end else begin
                    w_bit_cnt_next = r_bit_cnt + BC_W'(1);
                end
            end
        end

        // Preamble starts with 1 and alternates; even bit indices carry 1
        case (w_state_next)
            S_PRE:   w_sym_bit = ~w_bit_cnt_next[0];
            S_DATA:  w_sym_bit = w_shift_next[DATA_W-1];
            default: w_sym_bit = 1'b0;
        endcase

        if ((w_state_next == S_PRE) || (w_state_next == S_DATA)) begin
            w_dataout_next = w_phase_next ? w_sym_bit : ~w_sym_bit;
        end

        w_tx_done = (r_state == S_GAP) && w_last_bit && w_bit_end;
    end

    // State, counters, payload and line register; reset drops the line at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_half_cnt <= '0;
            r_phase    <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_dataout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_half_cnt <= w_half_cnt_next;
            r_phase    <= w_phase_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_dataout  <= w_dataout_next;
        end
    end

    assign bus.din_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.dataout   = r_dataout;
    assign bus.tx_done   = w_tx_done;

endmodule

// File: tb/tb_manch_encoder.sv
// Scoreboard bench for manch_encoder: a model predicts each accepted word's
// full line waveform; a monitor pops it when the encoder goes busy and
// compares the line cycle by cycle.
module tb_manch_encoder;
    localparam int DW  = 8;
    localparam int H   = 2;
    localparam int PRE = 4;
    localparam int GAP = 2;
    localparam int FL  = (PRE + DW + GAP) * 2 * H;

    typedef struct {
        logic [DW-1:0] w;
        logic [FL-1:0] bits;
    } frame_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail   = 0;

    frame_t exp_q[$];
    int     m_remaining = 0;

    bit            in_frame = 1'b0;
    int            idx = 0;
    int            td_bad = 0;
    int            busy_bad = 0;
    int            frames_done = 0;
    frame_t        cur;
    logic [FL-1:0] act_bits;

    always #5 clk = ~clk;

    manch_encoder_if #(.DATA_W(DW)) bus_if();

    manch_encoder #(
        .DATA_W(DW), .HALF_BIT_CLKS(H), .PREAMBLE_BITS(PRE), .GAP_BITS(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference waveform: list the logical bits, then expand each into
    // H cycles of its inverse followed by H cycles of itself; gap stays 0.
    function automatic logic [FL-1:0] make_frame(input logic [DW-1:0] w);
        logic [FL-1:0] f;
        bit            seq[$];
        int            k;
        f = '0;
        for (int i = 0; i < PRE; i++) seq.push_back((i % 2) == 0);
        for (int i = 0; i < DW; i++) seq.push_back(w[DW-1-i]);
        k = 0;
        foreach (seq[i]) begin
            for (int h = 0; h < H; h++) begin f[k] = !seq[i]; k++; end
            for (int h = 0; h < H; h++) begin f[k] = seq[i]; k++; end
        end
        return f;
    endfunction

    // Model: the encoder is free again FL+1 cycles after each acceptance
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_remaining <= 0;
        end else if (m_remaining > 0) begin
            m_remaining <= m_remaining - 1;
        end else if (bus_if.din_valid) begin
            exp_q.push_back('{w: bus_if.din, bits: make_frame(bus_if.din)});
            m_remaining <= FL;
        end
    end

    // Monitor: pops an expected frame when busy rises and checks the line
    always @(negedge clk) begin
        if (rst) begin
            if (in_frame) $display("frame word=%h aborted by reset at cycle %0d", cur.w, idx);
            in_frame = 1'b0;
        end else begin
            check("din_ready", bus_if.din_ready, m_remaining == 0);
            if (!in_frame && bus_if.busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    cur      = exp_q.pop_front();
                    in_frame = 1'b1;
                    idx      = 0;
                    td_bad   = 0;
                    busy_bad = 0;
                    act_bits = '0;
                end
            end
            if (in_frame) begin
                act_bits[idx] = bus_if.dataout;
                if (bus_if.tx_done !== (idx == FL - 1)) td_bad++;
                if (bus_if.busy !== 1'b1) busy_bad++;
                idx++;
                if (idx == FL) begin
                    check("frame_line", act_bits, cur.bits);
                    check("frame_tx_done", td_bad, 0);
                    check("frame_busy", busy_bad, 0);
                    frames_done++;
                    $display("frame %0d word=%h line=%h", frames_done, cur.w, act_bits);
                    in_frame = 1'b0;
                end
            end else begin
                check("idle_line", {bus_if.dataout, bus_if.tx_done}, 2'b00);
            end
        end
    end

    task automatic send(input logic [DW-1:0] w, input bit keep, output longint t);
        bit rdy;
        int n;
        n = 0;
        t = 0;
        bus_if.din       = w;
        bus_if.din_valid = 1'b1;
        forever begin
            @(negedge clk);
            rdy = bus_if.din_ready;
            @(posedge clk);
            n++;
            if (rdy) break;
            if (n >= FL * 4) begin
                check("send_timeout", 1, 0);
                break;
            end
        end
        #1;
        t = cyc;
        bus_if.din_valid = keep;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (!bus_if.busy && exp_q.size() == 0 && !in_frame && !bus_if.din_valid) break;
            if (n >= FL * 8) begin
                check("idle_timeout", 1, 0);
                break;
            end
        end
    endtask

    initial begin
        longint t1, t2;
        int     gap;
        bus_if.din       = '0;
        bus_if.din_valid = 1'b0;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_dataout", bus_if.dataout, 0);
        check("rst_busy", bus_if.busy, 0);
        check("rst_din_ready", bus_if.din_ready, 1);
        check("rst_tx_done", bus_if.tx_done, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_busy", bus_if.busy, 0);
        check("post_rst_din_ready", bus_if.din_ready, 1);

        // Single directed frame
        send(8'hA5, 1'b0, t1);
        wait_idle();

        // Back-to-back with din_valid held high
        send(8'hFF, 1'b1, t1);
        send(8'h00, 1'b0, t2);
        check("b2b_spacing", t2 - t1, FL + 1);
        wait_idle();

        // din_valid pulse while busy is ignored
        send(8'h5A, 1'b0, t1);
        repeat (10) @(posedge clk);
        #1;
        bus_if.din       = 8'h3C;
        bus_if.din_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.din_valid = 1'b0;
        wait_idle();

        // Reset during the third data bit (first half of a 0 bit: line high)
        send(8'hC5, 1'b0, t1);
        repeat (25) @(posedge clk);
        #2;
        check("pre_reset_line", bus_if.dataout, 1);
        #1 rst = 1'b1;
        #1;
        check("midrst_dataout", bus_if.dataout, 0);
        check("midrst_busy", bus_if.busy, 0);
        check("midrst_din_ready", bus_if.din_ready, 1);
        check("midrst_tx_done", bus_if.tx_done, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        send(8'h81, 1'b0, t1);
        wait_idle();

        // Randomized words, idle gaps and occasional stray valid pulses
        for (int i = 0; i < 16; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge clk);
            #1;
            send(DW'($urandom), 1'b0, t1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 40)) @(posedge clk);
                #1;
                bus_if.din       = DW'($urandom);
                bus_if.din_valid = 1'b1;
                @(posedge clk);
                #1;
                bus_if.din_valid = 1'b0;
            end
        end
        wait_idle();

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
